paralelo_serial: RTL and testbench
==================================

// Module: paralelo_serial
// PURPOSE
//  Transmit-side serializer feeding serial_paralelo. Accepts bytes over a valid/ready handshake
//  and shifts them out MSB-first, one bit per clk_32f edge, 8 bits per symbol.
//  After reset it sends SYNC_COUNT COM symbols (8'hBC) for receiver alignment, then sends data.
//  When no byte is pending, it sends COM as the idle fill.
// PARAMETERS
//  COM         8'hBC  alignment/idle symbol
//  SYNC_COUNT  4      COM symbols sent after reset before data is allowed (1..15)
// PORTS
//  clk_32f    in   1  bit clock; single clock domain, rising edge
//  reset      in   1  asynchronous, active-high
//  data_in    in   8  byte to transmit
//  valid_in   in   1  data_in is valid
//  ready_in   out  1  holding register empty; byte accepted on edge where valid_in&&ready_in
//  data_out   out  1  serial stream, registered
//  sym_start  out  1  registered; 1 while data_out carries bit 7 of a symbol
//  sym_data   out  1  registered; 1 for all 8 bits of a symbol taken from data_in (0 for COM)
//  active     out  1  registered; 1 once SYNC_COUNT COM symbols have been launched (RUN state)
// BEHAVIOUR
//  Reset (async, active-high):
//   - bit_cnt=0, shreg=0, hold_full=0, sync_cnt=0, state=SYNC.
//   - Outputs: data_out=0, sym_start=0, sym_data=0, active=0; ready_in=1.
//  Bit engine, on each edge:
//   - bit_cnt==0: choose symbol nxt; data_out<=nxt[7]; shreg<={nxt[6:0],1'b0}; sym_start<=1.
//   - otherwise: data_out<=shreg[7]; shreg<=shreg<<1; sym_start<=0.
//   - bit_cnt increments mod 8 every edge.
//  Symbol choice at bit_cnt==0:
//   - SYNC: nxt=COM; sync_cnt++. Hold register is not drained. When sync_cnt reaches SYNC_COUNT-1
//     on this edge, state<=RUN and active<=1 on the same edge.
//   - RUN with hold_full=1: nxt=hold; hold_full<=0; sym_data<=1.
//   - RUN with hold_full=0: nxt=COM; sym_data<=0.
//   - sym_data changes only on bit_cnt==0 edges.
//  Handshake:
//   - ready_in = !hold_full (combinational from a register).
//   - On accept, hold<=data_in and hold_full<=1.
//   - Accept and drain never coincide. A byte accepted on the edge after a drain is sent in the
//     next symbol, so full-rate streaming (1 byte per 8 clocks) is sustained.
//   - Accepting during SYNC is allowed. The byte is held and becomes the first RUN symbol.
//   - data_in equal to COM is sent unchanged with sym_data=1.
//  Latency: from the accept edge to the first data bit is 1..8 edges, depending on bit_cnt.
//  RUN is sticky until reset.
//  Reset mid-symbol:
//   - Truncates the symbol and discards any held byte.
//   - The sequence restarts with a full SYNC preamble from bit_cnt=0.
//  valid_in with ready_in=0: no capture. Source must hold data_in stable.
// TESTING
//  T1 Reset release, valid_in=0:
//     - data_out = 10111100 x4 (SYNC), active rises at edge 25 (bit_cnt==0 of 4th COM).
//     - Afterwards, COM repeats with sym_data=0.
//  T2 Single byte 8'hA5 offered during SYNC:
//     - ready_in falls at once.
//     - After the 4 COM symbols, 10100101 is sent with sym_data=1; ready_in returns at its sym_start.
//  T3 Back-to-back bytes 8'h01, 8'hFF, 8'h3C, each presented as soon as ready_in=1:
//     - Contiguous stream 00000001 11111111 00111100 with no COM between.
//     - Then COM idle.
//  T4 Byte 8'hBC as data:
//     - Sent as 10111100 with sym_data=1.
//     - The following idle COM has sym_data=0.
//  T5 Reset asserted mid-data (bit_cnt=4 of 8'hF0, hold holding 8'h0F):
//     - All outputs 0 immediately; ready_in=1.
//     - After release, 4 COM then idle. 8'h0F is never sent.
//  T6 Every symbol: sym_start high exactly 1 cycle in 8, aligned with bit 7.
//     - Cross-check via a serial_paralelo instance: its data_out matches each byte sent.

Source files
------------

// File: rtl/paralelo_serial.sv
`default_nettype none
// ============================================================================
//  Module   : paralelo_serial
//  Purpose  : Transmit-side byte serializer. Bytes arrive over a valid/ready
//             handshake into a one-entry holding register and are shifted out
//             MSB-first, one bit per clk_32f edge, eight bits per symbol.
//             After reset a preamble of SYNC_COUNT COM symbols is sent for
//             receiver alignment; afterwards COM is used as idle fill.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_32f    in   1  bit clock, rising edge
//    reset      in   1  asynchronous, active-high
//    data_in    in   8  byte to transmit
//    valid_in   in   1  data_in is valid
//    ready_in   out  1  holding register empty (byte taken when valid&&ready)
//    data_out   out  1  serial stream, registered
//    sym_start  out  1  high while data_out carries bit 7 of a symbol
//    sym_data   out  1  high for all 8 bits of a symbol taken from data_in
//    active     out  1  high once the COM preamble has been launched
// ============================================================================
module paralelo_serial #(
    parameter logic [7:0]  COM        = 8'hBC,
    parameter int unsigned SYNC_COUNT = 4
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready_in,
    output logic       data_out,
    output logic       sym_start,
    output logic       sym_data,
    output logic       active
);

    // Value of sync_cnt on the boundary edge that launches the last preamble COM.
    localparam logic [3:0] SYNC_LAST = 4'(SYNC_COUNT - 1);

    typedef enum logic [0:0] {
        SYNC = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t     state;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic [7:0] hold;
    logic       hold_full;
    logic [3:0] sync_cnt;

    logic [7:0] nxt;
    logic       drain;
    logic       accept;

    // Symbol selection: the held byte is only consumed on a symbol boundary
    // once the preamble is finished; everything else is COM.
    always_comb begin
        drain = (bit_cnt == 3'd0) && (state == RUN) && hold_full;
        nxt   = drain ? hold : COM;
    end

    // Accept needs an empty holding register while drain needs a full one,
    // so the two can never happen on the same edge.
    assign accept   = valid_in && !hold_full;
    assign ready_in = !hold_full;

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            state     <= SYNC;
            bit_cnt   <= 3'd0;
            shreg     <= 8'd0;
            hold      <= 8'd0;
            hold_full <= 1'b0;
            sync_cnt  <= 4'd0;
            data_out  <= 1'b0;
            sym_start <= 1'b0;
            sym_data  <= 1'b0;
            active    <= 1'b0;
        end else begin
            bit_cnt <= bit_cnt + 3'd1;

            if (bit_cnt == 3'd0) begin
                data_out  <= nxt[7];
                shreg     <= {nxt[6:0], 1'b0};
                sym_start <= 1'b1;
                sym_data  <= drain;
                if (state == SYNC) begin
                    sync_cnt <= sync_cnt + 4'd1;
                    // Switch on the edge that launches the final preamble COM,
                    // so the next boundary can already carry data.
                    if (sync_cnt == SYNC_LAST) begin
                        state  <= RUN;
                        active <= 1'b1;
                    end
                end
            end else begin
                data_out  <= shreg[7];
                shreg     <= {shreg[6:0], 1'b0};
                sym_start <= 1'b0;
            end

            if (drain) begin
                hold_full <= 1'b0;
            end else if (accept) begin
                hold      <= data_in;
                hold_full <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_paralelo_serial.sv
`default_nettype none
// ============================================================================
//  Module   : tb_paralelo_serial
//  Purpose  : Self-checking bench for paralelo_serial. Stimulus pushes every
//             accepted byte (with its accept edge) into a queue; a monitor
//             derives the expected symbol for each 8-edge slot from the
//             preamble/idle/data rules and compares the serial stream bit by
//             bit.
//  Revision : 1.0  initial release
// ============================================================================
module tb_paralelo_serial;

    localparam logic [7:0] COM  = 8'hBC;
    localparam int         SYNC = 4;

    logic       clk;
    logic       reset;
    logic [7:0] data_in;
    logic       valid_in;
    logic       ready_in;
    logic       data_out;
    logic       sym_start;
    logic       sym_data;
    logic       active;

    paralelo_serial #(
        .COM        (COM),
        .SYNC_COUNT (SYNC)
    ) dut (
        .clk_32f   (clk),
        .reset     (reset),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_in  (ready_in),
        .data_out  (data_out),
        .sym_start (sym_start),
        .sym_data  (sym_data),
        .active    (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        int         e;
    } acc_t;

    acc_t       acc_q[$];
    int         checks    = 0;
    int         failures  = 0;
    int         sent      = 0;
    int         data_syms = 0;
    int         edge_cnt;
    logic [7:0] exp_sym   = 8'h00;
    logic       exp_flag  = 1'b0;
    int         pos;
    int         n;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)",
                     name, act, exp, edge_cnt, $time);
        end
    endtask

    // Edges since the last reset release; edge 1 starts the first symbol.
    always @(posedge clk or posedge reset) begin
        if (reset) edge_cnt <= 0;
        else       edge_cnt <= edge_cnt + 1;
    end

    // Monitor: expected symbol for slot n starting at edge 8n+1 is COM during
    // the preamble, otherwise the oldest byte accepted strictly before that
    // edge, otherwise COM idle fill.
    always @(negedge clk) begin
        if (!reset && edge_cnt >= 1) begin
            pos = (edge_cnt - 1) % 8;
            n   = (edge_cnt - 1) / 8;
            if (pos == 0) begin
                if (n < SYNC) begin
                    exp_sym  = COM;
                    exp_flag = 1'b0;
                end else if (acc_q.size() > 0 && acc_q[0].e < edge_cnt) begin
                    exp_sym  = acc_q[0].b;
                    exp_flag = 1'b1;
                    void'(acc_q.pop_front());
                    data_syms++;
                end else begin
                    exp_sym  = COM;
                    exp_flag = 1'b0;
                end
                if (exp_flag) chk("ready_at_drain", int'(ready_in), 1);
            end
            chk("sym_start", int'(sym_start), int'(pos == 0));
            chk("data_out",  int'(data_out),  int'(exp_sym[7 - pos]));
            chk("sym_data",  int'(sym_data),  int'(exp_flag));
            chk("active",    int'(active),    int'(edge_cnt >= 8 * (SYNC - 1) + 1));
        end
    end

    // Called on a negedge; returns on a negedge.
    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        data_in  = b;
        valid_in = 1'b1;
        while (!ready_in && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        if (!ready_in) begin
            chk("ready_timeout", 0, 1);
            valid_in = 1'b0;
            return;
        end
        acc_q.push_back('{b: b, e: edge_cnt + 1});
        sent++;
        @(negedge clk);
        chk("ready_fall", int'(ready_in), 0);
        valid_in = 1'b0;
    endtask

    // Asserts reset between edges, checks the immediate output state.
    task automatic do_reset();
        #2 reset = 1'b1;
        sent -= acc_q.size();
        acc_q.delete();
        valid_in = 1'b0;
        #1;
        chk("rst_data_out",  int'(data_out),  0);
        chk("rst_sym_start", int'(sym_start), 0);
        chk("rst_sym_data",  int'(sym_data),  0);
        chk("rst_active",    int'(active),    0);
        chk("rst_ready_in",  int'(ready_in),  1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    initial begin
        reset    = 1'b1;
        valid_in = 1'b0;
        data_in  = 8'h00;
        @(negedge clk);

        // Preamble then idle COM, no traffic.
        do_reset();
        idle(8 * 7);

        // Byte offered during the preamble.
        do_reset();
        idle(5);
        send_byte(8'hA5);
        idle(8 * 6);

        // Back-to-back bytes, then COM used as data.
        send_byte(8'h01);
        send_byte(8'hFF);
        send_byte(8'h3C);
        idle(8 * 3);
        send_byte(COM);
        idle(8 * 3);

        // Randomised traffic with random gaps (zero gap holds valid while full).
        for (int i = 0; i < 40; i++) begin
            idle($urandom_range(0, 12));
            send_byte(8'($urandom_range(0, 255)));
        end
        idle(8 * 3);

        // Reset in the middle of a data symbol with a byte held.
        send_byte(8'hF0);
        send_byte(8'h0F);
        idle(2);
        do_reset();
        idle(8 * 8);

        chk("queue_drained", acc_q.size(), 0);
        chk("data_symbols",  data_syms, sent);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
